// File: rtl/spi_cfg_slave_if.sv
// SPI configuration bus between the ADC/PLL-style master and the register-bank target.
// The master drives the clock, select and data lines; the target returns read data with its pad enable.
interface spi_cfg_slave_if;
  logic sck;
  logic csb;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (
    output sck,
    output csb,
    output mosi,
    input  miso,
    input  miso_oe
  );

  modport slave (
    input  sck,
    input  csb,
    input  mosi,
    output miso,
    output miso_oe
  );
endinterface

// File: rtl/spi_cfg_slave.sv
// Mode-0, MSB-first, 24-bit SPI configuration target with a local bank of 8-bit registers.
// All SPI pins are oversampled in the clk domain; frames commit only when CSB returns high.
module spi_cfg_slave #(
  parameter int NREG = 16
) (
  input  logic                clk,
  input  logic                rst,
  spi_cfg_slave_if.slave      spi,
  output logic                wr_stb,
  output logic [14:0]         wr_addr,
  output logic [7:0]          wr_data,
  output logic                rd_stb,
  output logic                frame_err,
  output logic [8*NREG-1:0]   regs
);

  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_END
  } state_t;

  state_t      state, state_nx;

  logic        sck_meta, sck_s, sck_d;
  logic        csb_meta, csb_s, csb_d;
  logic        mosi_meta, mosi_s;
  logic        sck_rise, sck_fall, csb_rise;

  logic [23:0] shift_rx;
  logic [23:0] shift_nx;
  logic [4:0]  bit_cnt;
  logic        ovf;
  logic [7:0]  rd_sh;
  logic        rd_active;
  logic [7:0]  reg_q [NREG];

  logic        clr_cnt, do_shift, set_ovf, rd_load, rd_drive, end_clr, commit, err;

  logic [14:0] rd_addr;
  logic        rd_in_range;
  logic [7:0]  rd_byte;
  logic [14:0] frame_addr;
  logic [7:0]  frame_data;
  logic        frame_rw;
  logic        frame_in_range;

  // Idle levels are loaded at reset so a released reset never looks like an SCK or CSB edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_meta  <= 1'b0;
      sck_s     <= 1'b0;
      sck_d     <= 1'b0;
      csb_meta  <= 1'b1;
      csb_s     <= 1'b1;
      csb_d     <= 1'b1;
      mosi_meta <= 1'b0;
      mosi_s    <= 1'b0;
    end else begin
      sck_meta  <= spi.sck;
      sck_s     <= sck_meta;
      sck_d     <= sck_s;
      csb_meta  <= spi.csb;
      csb_s     <= csb_meta;
      csb_d     <= csb_s;
      mosi_meta <= spi.mosi;
      mosi_s    <= mosi_meta;
    end
  end

  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign csb_rise = csb_s & ~csb_d;

  assign shift_nx = {shift_rx[22:0], mosi_s};

  // The read address is complete on the edge that brings bit_cnt to 16, so it is taken from shift_nx.
  assign rd_addr     = shift_nx[14:0];
  assign rd_in_range = (32'(rd_addr) < NREG);
  assign rd_byte     = rd_in_range ? reg_q[rd_addr[AW-1:0]] : 8'h00;

  assign frame_rw       = shift_rx[23];
  assign frame_addr     = shift_rx[22:8];
  assign frame_data     = shift_rx[7:0];
  assign frame_in_range = (32'(frame_addr) < NREG);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    clr_cnt  = 1'b0;
    do_shift = 1'b0;
    set_ovf  = 1'b0;
    rd_load  = 1'b0;
    rd_drive = 1'b0;
    end_clr  = 1'b0;
    commit   = 1'b0;
    err      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!csb_s) begin
          state_nx = ST_SHIFT;
          clr_cnt  = 1'b1;
        end
      end
      ST_SHIFT: begin
        // A CSB rise in the same cycle as an SCK edge closes the frame and drops that edge.
        if (csb_rise) begin
          state_nx = ST_END;
        end else begin
          if (sck_rise) begin
            if (bit_cnt == 5'd24) begin
              set_ovf = 1'b1;
            end else begin
              do_shift = 1'b1;
              if (bit_cnt == 5'd15 && shift_nx[15]) begin
                rd_load = 1'b1;
              end
            end
          end
          if (sck_fall && rd_active && bit_cnt >= 5'd16 && bit_cnt <= 5'd23) begin
            rd_drive = 1'b1;
          end
        end
      end
      ST_END: begin
        state_nx = ST_IDLE;
        end_clr  = 1'b1;
        if (bit_cnt == 5'd24 && !ovf && !frame_rw) begin
          commit = 1'b1;
        end else if (ovf || (bit_cnt != 5'd0 && bit_cnt != 5'd24)) begin
          err = 1'b1;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_rx    <= '0;
      bit_cnt     <= '0;
      ovf         <= 1'b0;
      rd_sh       <= '0;
      rd_active   <= 1'b0;
      spi.miso    <= 1'b0;
      spi.miso_oe <= 1'b0;
      wr_stb      <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      rd_stb      <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      wr_stb    <= commit;
      rd_stb    <= rd_load;
      frame_err <= err;
      if (clr_cnt) begin
        bit_cnt   <= '0;
        ovf       <= 1'b0;
        rd_active <= 1'b0;
      end
      if (do_shift) begin
        shift_rx <= shift_nx;
        bit_cnt  <= bit_cnt + 5'd1;
      end
      if (set_ovf) begin
        ovf <= 1'b1;
      end
      if (rd_load) begin
        rd_sh     <= rd_byte;
        rd_active <= 1'b1;
      end
      if (rd_drive) begin
        spi.miso    <= rd_sh[7];
        spi.miso_oe <= 1'b1;
        rd_sh       <= {rd_sh[6:0], 1'b0};
      end
      if (end_clr) begin
        spi.miso    <= 1'b0;
        spi.miso_oe <= 1'b0;
        rd_active   <= 1'b0;
      end
      if (commit) begin
        wr_addr <= frame_addr;
        wr_data <= frame_data;
      end
    end
  end

  // Out-of-range writes still strobe externally but must not alias onto a low register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        reg_q[i] <= 8'h00;
      end
    end else if (commit && frame_in_range) begin
      reg_q[frame_addr[AW-1:0]] <= frame_data;
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_regs
    assign regs[8*g +: 8] = reg_q[g];
  end

endmodule

// File: tb/tb_spi_cfg_slave.sv
// Directed bench for spi_cfg_slave: a table of SPI frames with hand-computed results,
// followed by mid-frame reset and back-to-back write sequences.
module tb_spi_cfg_slave;

  localparam int NREG = 16;

  typedef struct {
    logic [23:0] frame;
    int          nbits;
    int          exp_wr;
    int          exp_rd;
    int          exp_err;
    logic [14:0] exp_waddr;
    logic [7:0]  exp_wdata;
    logic [7:0]  exp_miso;
    int          exp_oe;
    int          chk_reg;
    logic [7:0]  exp_reg;
  } vec_t;

  logic              clk;
  logic              rst;
  logic              wr_stb;
  logic [14:0]       wr_addr;
  logic [7:0]        wr_data;
  logic              rd_stb;
  logic              frame_err;
  logic [8*NREG-1:0] regs;

  int pass_cnt;
  int total_cnt;
  int wr_total;
  int rd_total;
  int err_total;

  spi_cfg_slave_if spi_if ();

  spi_cfg_slave #(.NREG(NREG)) dut (
    .clk       (clk),
    .rst       (rst),
    .spi       (spi_if.slave),
    .wr_stb    (wr_stb),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_stb    (rd_stb),
    .frame_err (frame_err),
    .regs      (regs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters run forever; each check works on the difference across a frame.
  initial begin
    wr_total  = 0;
    rd_total  = 0;
    err_total = 0;
    forever begin
      @(negedge clk);
      if (wr_stb)    wr_total++;
      if (rd_stb)    rd_total++;
      if (frame_err) err_total++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Master side: 5-clk SCK phases, mosi set on the low phase, miso sampled just before each rise.
  task automatic applyStimulus(input logic [23:0] frame, input int nbits, input int gap,
                               output logic [7:0] rd_byte, output int oe_hits);
    rd_byte = 8'h00;
    oe_hits = 0;
    spi_if.csb = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi_if.mosi = (i < 24) ? frame[23-i] : 1'b0;
      repeat (5) @(negedge clk);
      if (i >= 16 && i < 24) begin
        rd_byte = {rd_byte[6:0], spi_if.miso};
        if (spi_if.miso_oe) oe_hits++;
      end
      spi_if.sck = 1'b1;
      repeat (5) @(negedge clk);
      spi_if.sck = 1'b0;
    end
    repeat (5) @(negedge clk);
    spi_if.csb  = 1'b1;
    spi_if.mosi = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  vec_t vecs [8];

  initial begin
    logic [7:0] rd_byte;
    int         oe_hits;
    int         wr0, rd0, err0;

    pass_cnt  = 0;
    total_cnt = 0;

    vecs[0] = '{24'h0003AB, 24, 1, 0, 0, 15'h0003, 8'hAB, 8'h00, 0, 3, 8'hAB};
    vecs[1] = '{24'h800300, 24, 0, 1, 0, 15'h0003, 8'hAB, 8'hAB, 8, 3, 8'hAB};
    vecs[2] = '{24'h00055A, 20, 0, 0, 1, 15'h0003, 8'hAB, 8'h00, 0, 5, 8'h00};
    vecs[3] = '{24'h000577, 25, 0, 0, 1, 15'h0003, 8'hAB, 8'h00, 0, 5, 8'h00};
    vecs[4] = '{24'h001042, 24, 1, 0, 0, 15'h0010, 8'h42, 8'h00, 0, 0, 8'h00};
    vecs[5] = '{24'h801000, 24, 0, 1, 0, 15'h0010, 8'h42, 8'h00, 8, 0, 8'h00};
    vecs[6] = '{24'h00075C, 24, 1, 0, 0, 15'h0007, 8'h5C, 8'h00, 0, 7, 8'h5C};
    vecs[7] = '{24'h800700, 24, 0, 1, 0, 15'h0007, 8'h5C, 8'h5C, 8, 7, 8'h5C};

    rst         = 1'b1;
    spi_if.sck  = 1'b0;
    spi_if.csb  = 1'b1;
    spi_if.mosi = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    checkOutput("reset wr_addr", 32'(wr_addr), 32'h0);
    checkOutput("reset wr_data", 32'(wr_data), 32'h0);
    checkOutput("reset miso", 32'(spi_if.miso), 32'h0);
    checkOutput("reset miso_oe", 32'(spi_if.miso_oe), 32'h0);
    checkOutput("reset regs_nonzero", 32'(regs != '0), 32'h0);
    checkOutput("reset pulses", 32'(wr_total + rd_total + err_total), 32'h0);

    for (int v = 0; v < 8; v++) begin
      wr0  = wr_total;
      rd0  = rd_total;
      err0 = err_total;
      applyStimulus(vecs[v].frame, vecs[v].nbits, 10, rd_byte, oe_hits);
      $display("[TB] vector %0d frame 0x%06h bits %0d", v, vecs[v].frame, vecs[v].nbits);
      checkOutput($sformatf("v%0d wr_stb pulses", v), 32'(wr_total - wr0), 32'(vecs[v].exp_wr));
      checkOutput($sformatf("v%0d rd_stb pulses", v), 32'(rd_total - rd0), 32'(vecs[v].exp_rd));
      checkOutput($sformatf("v%0d frame_err pulses", v), 32'(err_total - err0), 32'(vecs[v].exp_err));
      checkOutput($sformatf("v%0d wr_addr", v), 32'(wr_addr), 32'(vecs[v].exp_waddr));
      checkOutput($sformatf("v%0d wr_data", v), 32'(wr_data), 32'(vecs[v].exp_wdata));
      checkOutput($sformatf("v%0d reg[%0d]", v, vecs[v].chk_reg),
                  32'(regs[8*vecs[v].chk_reg +: 8]), 32'(vecs[v].exp_reg));
      checkOutput($sformatf("v%0d miso_oe samples", v), 32'(oe_hits), 32'(vecs[v].exp_oe));
      if (vecs[v].exp_rd != 0) begin
        checkOutput($sformatf("v%0d miso byte", v), 32'(rd_byte), 32'(vecs[v].exp_miso));
      end
      checkOutput($sformatf("v%0d miso_oe idle", v), 32'(spi_if.miso_oe), 32'h0);
      checkOutput($sformatf("v%0d miso idle", v), 32'(spi_if.miso), 32'h0);
    end

    // Abort a write after 10 bits: reset must clear everything asynchronously.
    wr0  = wr_total;
    err0 = err_total;
    spi_if.csb = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      spi_if.mosi = 1'b1;
      repeat (5) @(negedge clk);
      spi_if.sck = 1'b1;
      repeat (5) @(negedge clk);
      spi_if.sck = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort regs cleared", 32'(regs != '0), 32'h0);
    checkOutput("abort wr_addr", 32'(wr_addr), 32'h0);
    checkOutput("abort wr_data", 32'(wr_data), 32'h0);
    checkOutput("abort miso_oe", 32'(spi_if.miso_oe), 32'h0);
    spi_if.csb  = 1'b1;
    spi_if.mosi = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    applyStimulus(24'h000711, 24, 10, rd_byte, oe_hits);
    checkOutput("post-reset wr_stb pulses", 32'(wr_total - wr0), 32'h1);
    checkOutput("post-reset frame_err pulses", 32'(err_total - err0), 32'h0);
    checkOutput("post-reset wr_addr", 32'(wr_addr), 32'h0007);
    checkOutput("post-reset wr_data", 32'(wr_data), 32'h11);
    checkOutput("post-reset reg[7]", 32'(regs[8*7 +: 8]), 32'h11);

    // Back-to-back writes with the minimum 4-clk CSB high gap.
    wr0  = wr_total;
    err0 = err_total;
    applyStimulus(24'h000001, 24, 4, rd_byte, oe_hits);
    applyStimulus(24'h000102, 24, 10, rd_byte, oe_hits);
    checkOutput("b2b wr_stb pulses", 32'(wr_total - wr0), 32'h2);
    checkOutput("b2b frame_err pulses", 32'(err_total - err0), 32'h0);
    checkOutput("b2b reg[0]", 32'(regs[8*0 +: 8]), 32'h01);
    checkOutput("b2b reg[1]", 32'(regs[8*1 +: 8]), 32'h02);
    checkOutput("b2b wr_addr", 32'(wr_addr), 32'h0001);
    checkOutput("b2b reg[7] kept", 32'(regs[8*7 +: 8]), 32'h11);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
